// File: rtl/mem_stage.sv
// Memory access stage: a load/store unit with IDLE/WAIT/DONE handshake, byte-lane steering and a timeout.
// Optional macro MEM_MISALIGN_CHK_EN blocks misaligned halfword/word accesses and pulses misalign instead.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] EX_MEM_ALU_result,
  input  logic [31:0] EX_MEM_rs2_data,
  input  logic [2:0]  EX_MEM_funct3,
  input  logic        EX_MEM_MemRead,
  input  logic        EX_MEM_MemWrite,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] ReadData,
  output logic        mem_stall,
  output logic        bus_err,
  output logic        misalign
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_nxt;
  logic        req_nxt, we_nxt, bus_err_nxt;
  logic [31:0] addr_nxt, wdata_nxt, rdata_nxt;
  logic [3:0]  be_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [2:0]  funct3_p1, funct3_nxt;
  logic [1:0]  lane_p1, lane_nxt;
  logic        load_p1, load_nxt;
  logic        access;
  logic        bad_align;

  // Size comes from funct3[1:0] (00 byte, 01 half, 1x word); funct3[2] selects zero-extension.
  function automatic logic [31:0] load_align(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [1:0] a);
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    byte_s = word[{a, 3'b000} +: 8];
    half_s = word[{a[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  load_align = 32'(byte_s);
      3'b100:  load_align = {24'd0, byte_s};
      3'b001:  load_align = 32'(half_s);
      3'b101:  load_align = {16'd0, half_s};
      default: load_align = word;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   store_be = 4'b0001 << a;
      2'b01:   store_be = 4'b0011 << {a[1], 1'b0};
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   store_wdata = {4{d[7:0]}};
      2'b01:   store_wdata = {2{d[15:0]}};
      default: store_wdata = d;
    endcase
  endfunction

  assign access    = EX_MEM_MemRead | EX_MEM_MemWrite;
  assign mem_stall = ((state == IDLE) && access) || (state == WAIT);

`ifdef MEM_MISALIGN_CHK_EN
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = a[0];
      default: is_misaligned = (a != 2'b00);
    endcase
  endfunction

  assign bad_align = is_misaligned(EX_MEM_funct3, EX_MEM_ALU_result[1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign <= 1'b0;
    else     misalign <= (state == IDLE) && access && bad_align;
  end
`else
  assign bad_align = 1'b0;
  assign misalign  = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    req_nxt     = dmem_req;
    we_nxt      = dmem_we;
    addr_nxt    = dmem_addr;
    be_nxt      = dmem_be;
    wdata_nxt   = dmem_wdata;
    rdata_nxt   = ReadData;
    bus_err_nxt = 1'b0;
    cnt_nxt     = cnt;
    funct3_nxt  = funct3_p1;
    lane_nxt    = lane_p1;
    load_nxt    = load_p1;
    case (state)
      IDLE: begin
        if (access) begin
          if (bad_align) begin
            state_nxt = DONE;
            rdata_nxt = '0;
          end else begin
            // A simultaneous read and write is issued as a store.
            state_nxt  = WAIT;
            req_nxt    = 1'b1;
            we_nxt     = EX_MEM_MemWrite;
            addr_nxt   = {EX_MEM_ALU_result[31:2], 2'b00};
            be_nxt     = store_be(EX_MEM_funct3, EX_MEM_ALU_result[1:0]);
            wdata_nxt  = store_wdata(EX_MEM_funct3, EX_MEM_rs2_data);
            funct3_nxt = EX_MEM_funct3;
            lane_nxt   = EX_MEM_ALU_result[1:0];
            load_nxt   = ~EX_MEM_MemWrite;
            cnt_nxt    = 8'd0;
          end
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          state_nxt = DONE;
          req_nxt   = 1'b0;
          we_nxt    = 1'b0;
          if (load_p1) rdata_nxt = load_align(dmem_rdata, funct3_p1, lane_p1);
        end else if (cnt == TO_LAST) begin
          state_nxt   = DONE;
          req_nxt     = 1'b0;
          we_nxt      = 1'b0;
          rdata_nxt   = '0;
          bus_err_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
      ReadData   <= '0;
      bus_err    <= 1'b0;
      cnt        <= '0;
      funct3_p1  <= '0;
      lane_p1    <= '0;
      load_p1    <= 1'b0;
    end else begin
      state      <= state_nxt;
      dmem_req   <= req_nxt;
      dmem_we    <= we_nxt;
      dmem_addr  <= addr_nxt;
      dmem_wdata <= wdata_nxt;
      dmem_be    <= be_nxt;
      ReadData   <= rdata_nxt;
      bus_err    <= bus_err_nxt;
      cnt        <= cnt_nxt;
      funct3_p1  <= funct3_nxt;
      lane_p1    <= lane_nxt;
      load_p1    <= load_nxt;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: lane steering, stall length, timeout, reset abort and alignment handling.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu, rs2, rdata, addr_o, wdata_o, rd_o;
  logic [2:0]  f3;
  logic        mrd, mwr, ack, req, we, stall, berr, mis;
  logic [3:0]  be_o;

  int n_cmp = 0;
  int n_err = 0;

  int          r_stall, r_reqcyc;
  logic [31:0] r_addr, r_wdata, r_rd;
  logic [3:0]  r_be;
  logic        r_we, r_berr, r_mis, r_stable;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .EX_MEM_ALU_result(alu), .EX_MEM_rs2_data(rs2), .EX_MEM_funct3(f3),
    .EX_MEM_MemRead(mrd), .EX_MEM_MemWrite(mwr),
    .dmem_req(req), .dmem_we(we), .dmem_addr(addr_o), .dmem_wdata(wdata_o), .dmem_be(be_o),
    .dmem_ack(ack), .dmem_rdata(rdata),
    .ReadData(rd_o), .mem_stall(stall), .bus_err(berr), .misalign(mis)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one access from its IDLE cycle to its DONE cycle; acks in WAIT cycle number ack_after.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] fn,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] mem_word, input int ack_after);
    bit fin;
    int w;
    @(negedge clk);
    mrd = rd; mwr = wr; f3 = fn; alu = a; rs2 = d; ack = 1'b0;
    r_stall = 0; r_reqcyc = 0; r_stable = 1'b1; fin = 1'b0; w = 0;
    r_addr = '0; r_wdata = '0; r_be = '0; r_we = 1'b0; r_rd = '0; r_berr = 1'b0; r_mis = 1'b0;
    for (int i = 0; i < 40 && !fin; i++) begin
      #1;
      if (stall) begin
        r_stall++;
        if (req) begin
          if (r_reqcyc == 0) begin
            r_addr = addr_o; r_wdata = wdata_o; r_be = be_o; r_we = we;
          end else if ({addr_o, wdata_o, be_o, we} !== {r_addr, r_wdata, r_be, r_we}) begin
            r_stable = 1'b0;
          end
          r_reqcyc++;
          ack   = (w == ack_after);
          rdata = mem_word;
          w++;
        end
        @(negedge clk);
      end else begin
        fin = 1'b1;
        r_rd = rd_o; r_berr = berr; r_mis = mis;
      end
    end
    if (!fin) check("access_bound", 32'd0, 32'd1);
    mrd = 1'b0; mwr = 1'b0; ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; alu = '0; rs2 = '0; rdata = '0; f3 = '0; mrd = 1'b0; mwr = 1'b0; ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req",   32'(req), 32'd0);
    check("rst_we",    32'(we), 32'd0);
    check("rst_addr",  addr_o, 32'd0);
    check("rst_wdata", wdata_o, 32'd0);
    check("rst_be",    32'(be_o), 32'd0);
    check("rst_rd",    rd_o, 32'd0);
    check("rst_berr",  32'(berr), 32'd0);
    check("rst_mis",   32'(mis), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;

    run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    check("lw_stall", 32'(r_stall), 32'd2);
    check("lw_addr",  r_addr, 32'h100);
    check("lw_be",    32'(r_be), 32'hF);
    check("lw_we",    32'(r_we), 32'd0);
    check("lw_rd",    r_rd, 32'hDEADBEEF);
    check("lw_berr",  32'(r_berr), 32'd0);
    @(negedge clk); #1;
    check("done_to_idle_req", 32'(req), 32'd0);

    run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 1);
    check("lb_stall", 32'(r_stall), 32'd3);
    check("lb_addr",  r_addr, 32'h100);
    check("lb_be",    32'(r_be), 32'h8);
    check("lb_rd",    r_rd, 32'hFFFFFF80);

    run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 0);
    check("lbu_rd", r_rd, 32'h00000080);

    run_access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80123456, 0);
    check("lhu_be", 32'(r_be), 32'hC);
    check("lhu_rd", r_rd, 32'h00008012);

    run_access(1'b1, 1'b0, 3'b001, 32'h100, 32'h0, 32'h12348001, 0);
    check("lh_rd", r_rd, 32'hFFFF8001);

    run_access(1'b0, 1'b1, 3'b000, 32'h201, 32'h000000AB, 32'hFFFFFFFF, 2);
    check("sb_stall",  32'(r_stall), 32'd4);
    check("sb_addr",   r_addr, 32'h200);
    check("sb_be",     32'(r_be), 32'h2);
    check("sb_wdata",  r_wdata, 32'hABABABAB);
    check("sb_we",     32'(r_we), 32'd1);
    check("sb_stable", 32'(r_stable), 32'd1);
    check("sb_rd",     r_rd, 32'hFFFF8001);

    run_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234CDEF, 32'hFFFFFFFF, 0);
    check("sh_be",    32'(r_be), 32'hC);
    check("sh_wdata", r_wdata, 32'hCDEFCDEF);
    check("sh_rd",    r_rd, 32'hFFFF8001);

    run_access(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'h5A5A5A5A, 100);
    check("to_reqcyc", 32'(r_reqcyc), 32'd4);
    check("to_stall",  32'(r_stall), 32'd5);
    check("to_berr",   32'(r_berr), 32'd1);
    check("to_rd",     r_rd, 32'd0);
    @(negedge clk); #1;
    check("to_berr_pulse", 32'(berr), 32'd0);
    check("to_req_low",    32'(req), 32'd0);

    run_access(1'b1, 1'b1, 3'b010, 32'h304, 32'h55AA55AA, 32'hFFFFFFFF, 0);
    check("rw_we",    32'(r_we), 32'd1);
    check("rw_wdata", r_wdata, 32'h55AA55AA);
    check("rw_rd",    r_rd, 32'd0);

    run_access(1'b1, 1'b0, 3'b111, 32'h10C, 32'h0, 32'h01020304, 0);
    check("f111_be", 32'(r_be), 32'hF);
    check("f111_rd", r_rd, 32'h01020304);

    run_access(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'hCAFEF00D, 0);
`ifdef MEM_MISALIGN_CHK_EN
    check("mis_reqcyc", 32'(r_reqcyc), 32'd0);
    check("mis_flag",   32'(r_mis), 32'd1);
    check("mis_stall",  32'(r_stall), 32'd1);
    check("mis_rd",     r_rd, 32'd0);
`else
    check("mis_addr",  r_addr, 32'h100);
    check("mis_flag",  32'(r_mis), 32'd0);
    check("mis_stall", 32'(r_stall), 32'd2);
    check("mis_rd",    r_rd, 32'hCAFEF00D);
`endif

    @(negedge clk);
    ack = 1'b1; rdata = 32'h77777777;
    @(negedge clk); #1;
    check("idle_ack_req",   32'(req), 32'd0);
    check("idle_ack_stall", 32'(stall), 32'd0);
    ack = 1'b0;

    @(negedge clk);
    mwr = 1'b1; f3 = 3'b010; alu = 32'h300; rs2 = 32'h11223344;
    @(negedge clk); #1;
    check("rstw_req", 32'(req), 32'd1);
    rst = 1'b1; mwr = 1'b0;
    #1;
    check("rstw_req_drop", 32'(req), 32'd0);
    check("rstw_we",       32'(we), 32'd0);
    check("rstw_stall",    32'(stall), 32'd0);
    check("rstw_berr",     32'(berr), 32'd0);
    @(negedge clk); #1;
    check("rstw_berr_hold", 32'(berr), 32'd0);
    @(negedge clk);
    rst = 1'b0; mrd = 1'b1; f3 = 3'b010; alu = 32'h400;
    @(negedge clk); #1;
    check("first_req",  32'(req), 32'd1);
    check("first_addr", addr_o, 32'h400);
    ack = 1'b1; rdata = 32'h0BADF00D;
    @(negedge clk); #1;
    check("first_rd",    rd_o, 32'h0BADF00D);
    check("first_stall", 32'(stall), 32'd0);
    mrd = 1'b0; ack = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
